// File: rtl/dmem_pkg.sv
// dmem_pkg: shared definitions for the data-RAM arbiter.
//   - arb_state_e : starvation FSM encoding (idle / waiting / forced slot)
//   - DMEM_ADDR_W : RAM word-address width (1024 words)
//   - WSEL_LO/HI  : byte-address bits that select a RAM word ([11:2])
package dmem_pkg;

    localparam int unsigned DMEM_ADDR_W = 10;

    // Byte address -> word address: drop the two byte-offset bits.
    localparam int unsigned WSEL_LO = 2;
    localparam int unsigned WSEL_HI = DMEM_ADDR_W + 1;

    typedef enum logic [1:0] {
        ARB_IDLE  = 2'd0,
        ARB_WAIT  = 2'd1,
        ARB_FORCE = 2'd2
    } arb_state_e;

endpackage

// File: rtl/arb_starve_ctr.sv
// arb_starve_ctr: starvation FSM and saturating wait counter for dmem_arbiter.
// Counts cycles that a secondary request is blocked by the pipeline and, after
// STARVE_LIMIT of them, raises 'forced' for one cycle so the top level steals a
// RAM slot from the pipeline.
//
// Ports:
//   clk, rst    clock, asynchronous active-high reset
//   s_req       secondary request (held until granted)
//   s_gnt       secondary grant from the top level
//   forced      state register is ARB_FORCE (grant the secondary this cycle)
//   state_next  next-state value of the FSM
module arb_starve_ctr
    import dmem_pkg::*;
#(
    parameter int unsigned STARVE_LIMIT = 8,
    parameter int unsigned CNT_W        = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       s_req,
    input  logic       s_gnt,
    output logic       forced,
    output arb_state_e state_next
);

    localparam logic [CNT_W-1:0] LimitC = CNT_W'(STARVE_LIMIT);

    arb_state_e       state_q, state_d;
    logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ARB_IDLE;
            wait_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        unique case (state_q)
            ARB_IDLE: begin
                if (s_req && !s_gnt) begin
                    state_d    = ARB_WAIT;
                    wait_cnt_d = CNT_W'(1);
                end else begin
                    wait_cnt_d = '0;
                end
            end
            ARB_WAIT: begin
                if (s_gnt || !s_req) begin
                    state_d    = ARB_IDLE;
                    wait_cnt_d = '0;
                end else begin
                    // Saturate rather than wrap, so a mis-set limit cannot
                    // silently restart the count.
                    if (wait_cnt_q != '1) begin
                        wait_cnt_d = wait_cnt_q + CNT_W'(1);
                    end
                    if (wait_cnt_d >= LimitC) begin
                        state_d = ARB_FORCE;
                    end
                end
            end
            ARB_FORCE: begin
                // Grant is guaranteed here; a dropped request just returns idle.
                state_d    = ARB_IDLE;
                wait_cnt_d = '0;
            end
            default: begin
                state_d    = ARB_IDLE;
                wait_cnt_d = '0;
            end
        endcase
    end

    assign forced     = (state_q == ARB_FORCE);
    assign state_next = state_d;

endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares the single data RAM between the pipeline MEM stage
// (priority master) and a secondary debug/DMA master. The secondary uses idle
// pipeline cycles; a starvation counter forces a one-cycle pipeline stall to
// give the secondary a slot when it has been blocked too long.
//
// Ports:
//   clk, rst                  clock, asynchronous active-high reset
//   p_ren, p_wen              pipeline load / store
//   p_addr, p_wdata           pipeline byte address, store data
//   p_rdata                   load data (straight from ram_dout)
//   p_stall                   pipeline must hold MEM/WB this cycle
//   s_req, s_we, s_addr,
//   s_wdata                   secondary request, direction, word addr, data
//   s_gnt                     secondary owns the RAM this cycle
//   s_rdata, s_valid          registered secondary read data + 1-cycle valid
//   ram_write, ram_addr,
//   ram_din, ram_dout         RAM interface (asynchronous read)
//
// Optional: define DMEM_ARB_STATS_EN to add stat_conflicts (cycles with both
// masters active) and stat_forced (forced grants), 16-bit saturating counters.
module dmem_arbiter
    import dmem_pkg::*;
#(
    parameter int unsigned ADDR_W       = DMEM_ADDR_W,
    parameter int unsigned STARVE_LIMIT = 8,
    parameter int unsigned CNT_W        = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              p_ren,
    input  logic              p_wen,
    input  logic [31:0]       p_addr,
    input  logic [31:0]       p_wdata,
    output logic [31:0]       p_rdata,
    output logic              p_stall,
    input  logic              s_req,
    input  logic              s_we,
    input  logic [ADDR_W-1:0] s_addr,
    input  logic [31:0]       s_wdata,
    output logic              s_gnt,
    output logic [31:0]       s_rdata,
    output logic              s_valid,
    output logic              ram_write,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [31:0]       ram_din,
    input  logic [31:0]       ram_dout
`ifdef DMEM_ARB_STATS_EN
    ,
    output logic [15:0]       stat_conflicts,
    output logic [15:0]       stat_forced
`endif
);

    logic       p_act;
    logic       forced;
    arb_state_e unused_state_next;
    logic       unused_addr_bits;

    logic [31:0] s_rdata_q;
    logic        s_valid_q;

    assign unused_addr_bits = ^{p_addr[31:ADDR_W+WSEL_LO], p_addr[WSEL_LO-1:0]};

    arb_starve_ctr #(
        .STARVE_LIMIT (STARVE_LIMIT),
        .CNT_W        (CNT_W)
    ) u_ctr (
        .clk        (clk),
        .rst        (rst),
        .s_req      (s_req),
        .s_gnt      (s_gnt),
        .forced     (forced),
        .state_next (unused_state_next)
    );

    always_comb begin
        p_act   = p_ren | p_wen;
        s_gnt   = s_req & ~rst & (~p_act | forced);
        p_stall = p_act & s_req & forced & ~rst;
    end

    // RAM mux: the granted secondary wins outright, including on a same-address
    // collision; the stalled pipeline retries next cycle.
    always_comb begin
        ram_write = 1'b0;
        ram_addr  = p_addr[ADDR_W+WSEL_LO-1:WSEL_LO];
        ram_din   = p_wdata;
        if (s_gnt) begin
            ram_addr  = s_addr;
            ram_din   = s_wdata;
            ram_write = s_we;
        end else begin
            ram_write = p_wen & ~p_stall & ~rst;
        end
    end

    assign p_rdata = ram_dout;

    // Secondary read capture: s_rdata holds until the next granted read.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s_rdata_q <= '0;
            s_valid_q <= 1'b0;
        end else begin
            s_valid_q <= s_gnt & ~s_we;
            if (s_gnt && !s_we) begin
                s_rdata_q <= ram_dout;
            end
        end
    end

    assign s_rdata = s_rdata_q;
    assign s_valid = s_valid_q;

`ifdef DMEM_ARB_STATS_EN
    logic [15:0] stat_conflicts_q;
    logic [15:0] stat_forced_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stat_conflicts_q <= '0;
            stat_forced_q    <= '0;
        end else begin
            if (p_act && s_req && stat_conflicts_q != 16'hFFFF) begin
                stat_conflicts_q <= stat_conflicts_q + 16'd1;
            end
            if (forced && s_gnt && stat_forced_q != 16'hFFFF) begin
                stat_forced_q <= stat_forced_q + 16'd1;
            end
        end
    end

    assign stat_conflicts = stat_conflicts_q;
    assign stat_forced    = stat_forced_q;
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: self-checking bench for dmem_arbiter with a behavioural
// 1024x32 RAM (asynchronous read, write on rising edge).
module tb_dmem_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        p_ren, p_wen;
    logic [31:0] p_addr, p_wdata, p_rdata;
    logic        p_stall;
    logic        s_req, s_we;
    logic [9:0]  s_addr;
    logic [31:0] s_wdata;
    logic        s_gnt;
    logic [31:0] s_rdata;
    logic        s_valid;
    logic        ram_write;
    logic [9:0]  ram_addr;
    logic [31:0] ram_din, ram_dout;
`ifdef DMEM_ARB_STATS_EN
    logic [15:0] stat_conflicts, stat_forced;
`endif

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    dmem_arbiter dut (
        .clk       (clk),
        .rst       (rst),
        .p_ren     (p_ren),
        .p_wen     (p_wen),
        .p_addr    (p_addr),
        .p_wdata   (p_wdata),
        .p_rdata   (p_rdata),
        .p_stall   (p_stall),
        .s_req     (s_req),
        .s_we      (s_we),
        .s_addr    (s_addr),
        .s_wdata   (s_wdata),
        .s_gnt     (s_gnt),
        .s_rdata   (s_rdata),
        .s_valid   (s_valid),
        .ram_write (ram_write),
        .ram_addr  (ram_addr),
        .ram_din   (ram_din),
        .ram_dout  (ram_dout)
`ifdef DMEM_ARB_STATS_EN
        ,
        .stat_conflicts (stat_conflicts),
        .stat_forced    (stat_forced)
`endif
    );

    logic [31:0] mem [0:1023];
    always @(posedge clk) begin
        if (ram_write) mem[ram_addr] <= ram_din;
    end
    assign ram_dout = mem[ram_addr];

    typedef struct {
        logic        p_ren;
        logic        p_wen;
        logic [31:0] p_addr;
        logic [31:0] p_wdata;
        logic        s_req;
        logic        s_we;
        logic [9:0]  s_addr;
        logic [31:0] s_wdata;
        logic        e_gnt;
        logic        e_stall;
        logic        e_wr;
        logic [9:0]  e_addr;
        logic [31:0] e_din;
        logic [31:0] e_prd;
        logic        e_sv;
        logic [31:0] e_srd;
    } vec_t;

    vec_t vecs [6];

    task automatic check1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        p_ren   = 1'b0;
        p_wen   = 1'b0;
        p_addr  = '0;
        p_wdata = '0;
        s_req   = 1'b0;
        s_we    = 1'b0;
        s_addr  = '0;
        s_wdata = '0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        idle_inputs();
        tick();
        tick();
        rst = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = '0;

        //            p_ren p_wen p_addr        p_wdata       s_req s_we s_addr  s_wdata
        //            gnt   stall wr    addr     din           prd           sv    srd
        vecs[0] = '{1'b0, 1'b0, 32'h0000_0000, 32'h0,        1'b1, 1'b1, 10'h005, 32'hCAFEBABE,
                    1'b1, 1'b0, 1'b1, 10'h005, 32'hCAFEBABE, 32'h0,        1'b0, 32'h0};
        vecs[1] = '{1'b0, 1'b1, 32'h0000_0010, 32'h1234,     1'b0, 1'b0, 10'h000, 32'h0,
                    1'b0, 1'b0, 1'b1, 10'h004, 32'h1234,     32'h0,        1'b0, 32'h0};
        vecs[2] = '{1'b1, 1'b0, 32'h0000_0010, 32'h0,        1'b0, 1'b0, 10'h000, 32'h0,
                    1'b0, 1'b0, 1'b0, 10'h004, 32'h0,        32'h1234,     1'b0, 32'h0};
        vecs[3] = '{1'b1, 1'b0, 32'h0000_0040, 32'h0,        1'b1, 1'b0, 10'h003, 32'h0,
                    1'b0, 1'b0, 1'b0, 10'h010, 32'h0,        32'h0,        1'b0, 32'h0};
        vecs[4] = '{1'b0, 1'b0, 32'h0000_0000, 32'h0,        1'b1, 1'b0, 10'h005, 32'h0,
                    1'b1, 1'b0, 1'b0, 10'h005, 32'h0,        32'hCAFEBABE, 1'b1, 32'hCAFEBABE};
        vecs[5] = '{1'b0, 1'b1, 32'h0000_1008, 32'h77,       1'b1, 1'b0, 10'h003, 32'h0,
                    1'b0, 1'b0, 1'b1, 10'h002, 32'h77,       32'h0,        1'b0, 32'hCAFEBABE};

        // Reset state: masters active while rst is high must not reach the RAM.
        rst     = 1'b1;
        idle_inputs();
        p_wen   = 1'b1;
        s_req   = 1'b1;
        s_we    = 1'b1;
        #2;
        check1("reset_s_gnt", s_gnt, 1'b0);
        check1("reset_p_stall", p_stall, 1'b0);
        check1("reset_ram_write", ram_write, 1'b0);
        check1("reset_s_valid", s_valid, 1'b0);
        check32("reset_s_rdata", s_rdata, 32'h0);
        idle_inputs();
        tick();
        tick();
        rst = 1'b0;

        // Single-cycle vectors, each followed by an idle cycle to return the FSM to idle.
        for (int i = 0; i < 6; i++) begin
            p_ren   = vecs[i].p_ren;
            p_wen   = vecs[i].p_wen;
            p_addr  = vecs[i].p_addr;
            p_wdata = vecs[i].p_wdata;
            s_req   = vecs[i].s_req;
            s_we    = vecs[i].s_we;
            s_addr  = vecs[i].s_addr;
            s_wdata = vecs[i].s_wdata;
            #2;
            check1($sformatf("vec%0d_s_gnt", i), s_gnt, vecs[i].e_gnt);
            check1($sformatf("vec%0d_p_stall", i), p_stall, vecs[i].e_stall);
            check1($sformatf("vec%0d_ram_write", i), ram_write, vecs[i].e_wr);
            check32($sformatf("vec%0d_ram_addr", i), {22'h0, ram_addr}, {22'h0, vecs[i].e_addr});
            check32($sformatf("vec%0d_ram_din", i), ram_din, vecs[i].e_din);
            check32($sformatf("vec%0d_p_rdata", i), p_rdata, vecs[i].e_prd);
            tick();
            check1($sformatf("vec%0d_s_valid", i), s_valid, vecs[i].e_sv);
            check32($sformatf("vec%0d_s_rdata", i), s_rdata, vecs[i].e_srd);
            idle_inputs();
            tick();
        end

        // Continuous contention: forced slot on cycles 8 and 17.
        do_reset();
        p_ren  = 1'b1;
        s_req  = 1'b1;
        s_we   = 1'b0;
        s_addr = 10'h005;
        for (int c = 0; c < 18; c++) begin
            #2;
            check1($sformatf("starve_c%0d_s_gnt", c), s_gnt, (c % 9) == 8);
            check1($sformatf("starve_c%0d_p_stall", c), p_stall, (c % 9) == 8);
            check1($sformatf("starve_c%0d_s_valid", c), s_valid, c == 9);
            if (c == 9) check32("starve_s_rdata", s_rdata, 32'hCAFEBABE);
            tick();
        end
`ifdef DMEM_ARB_STATS_EN
        check32("stat_conflicts", {16'h0, stat_conflicts}, 32'd18);
        check32("stat_forced", {16'h0, stat_forced}, 32'd2);
`endif

        // Same-address write collision in the forced cycle.
        do_reset();
        p_wen   = 1'b1;
        p_addr  = 32'h0000_0080;
        p_wdata = 32'hAAAA;
        s_req   = 1'b1;
        s_we    = 1'b1;
        s_addr  = 10'h020;
        s_wdata = 32'h5555;
        for (int c = 0; c < 9; c++) begin
            #2;
            if (c < 8) begin
                check1($sformatf("coll_c%0d_s_gnt", c), s_gnt, 1'b0);
                check32($sformatf("coll_c%0d_ram_din", c), ram_din, 32'hAAAA);
            end else begin
                check1("coll_force_s_gnt", s_gnt, 1'b1);
                check1("coll_force_p_stall", p_stall, 1'b1);
                check1("coll_force_ram_write", ram_write, 1'b1);
                check32("coll_force_ram_addr", {22'h0, ram_addr}, 32'h20);
                check32("coll_force_ram_din", ram_din, 32'h5555);
            end
            tick();
        end
        s_req = 1'b0;
        #2;
        check1("coll_retry_p_stall", p_stall, 1'b0);
        check1("coll_retry_ram_write", ram_write, 1'b1);
        check32("coll_retry_ram_din", ram_din, 32'hAAAA);
        check32("coll_retry_sees_forced_write", p_rdata, 32'h5555);
        tick();
        p_wen = 1'b0;
        p_ren = 1'b1;
        #2;
        check32("coll_pipe_readback", p_rdata, 32'hAAAA);
        tick();
        p_ren = 1'b0;
        s_req = 1'b1;
        s_we  = 1'b0;
        #2;
        check1("coll_sec_read_gnt", s_gnt, 1'b1);
        tick();
        check1("coll_sec_read_valid", s_valid, 1'b1);
        check32("coll_sec_read_data", s_rdata, 32'hAAAA);
        idle_inputs();
        tick();

        // Reset while waiting with count 5: count discarded, restarts from 1.
        do_reset();
        p_ren  = 1'b1;
        s_req  = 1'b1;
        s_we   = 1'b0;
        s_addr = 10'h005;
        for (int c = 0; c < 5; c++) tick();
        #2;
        check1("midwait_s_gnt", s_gnt, 1'b0);
        rst     = 1'b1;
        p_wen   = 1'b1;
        p_addr  = 32'h0000_0400;
        p_wdata = 32'hDEAD;
        #1;
        check1("midwait_rst_s_gnt", s_gnt, 1'b0);
        check1("midwait_rst_p_stall", p_stall, 1'b0);
        check1("midwait_rst_ram_write", ram_write, 1'b0);
        check1("midwait_rst_s_valid", s_valid, 1'b0);
        tick();
        check1("midwait_rst_edge_ram_write", ram_write, 1'b0);
        check32("midwait_rst_s_rdata", s_rdata, 32'h0);
        rst   = 1'b0;
        p_wen = 1'b0;
        for (int c = 0; c < 9; c++) begin
            #2;
            check1($sformatf("restart_c%0d_s_gnt", c), s_gnt, c == 8);
            check1($sformatf("restart_c%0d_p_stall", c), p_stall, c == 8);
            tick();
        end

        idle_inputs();
        tick();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
